// File: rtl/m_uart_loader.sv
// m_uart_loader: receives an 8N1 UART stream carrying a length header and a
// big-endian word image, and writes the image into a 4K-word memory. Once
// the last word has been written, r_done rises and releases the processor.
module m_uart_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_rxd,
  output logic        r_we,
  output logic [11:0] r_addr,
  output logic [31:0] r_wdata,
  output logic        r_done,
  output logic        r_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} rx_state_t;
  typedef enum logic [2:0] {P_HI, P_LO, P_DATA, P_DONE, P_ERR} p_state_t;

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] tick;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          byte_valid;
  logic          stop_bad;

  p_state_t      p_state;
  logic [7:0]    hdr_hi;
  logic [11:0]   remaining;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_acc;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= w_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A bad stop bit is flagged in the sampling cycle so the parser can react
  // on the same edge that would otherwise have produced byte_valid.
  always_comb begin
    stop_bad = 1'b0;
    if (rx_state == STOP && tick == LAST_TICK && !rx_sync) begin
      stop_bad = 1'b1;
    end else begin
      stop_bad = 1'b0;
    end
  end

  // UART receiver: mid-bit sampling, LSB first, one-cycle byte_valid pulse.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      rx_state   <= IDLE;
      tick       <= '0;
      bit_idx    <= 3'd0;
      rx_shift   <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (rx_state)
        IDLE: begin
          tick <= '0;
          if (rx_prev && !rx_sync) rx_state <= START;
        end
        START: begin
          if (tick == HALF_TICK) begin
            tick    <= '0;
            bit_idx <= 3'd0;
            // Line back high at mid start bit: treat as a glitch.
            rx_state <= rx_sync ? IDLE : BITS;
          end else begin
            tick <= tick + CW'(1);
          end
        end
        BITS: begin
          if (tick == LAST_TICK) begin
            tick     <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= STOP;
          end else begin
            tick <= tick + CW'(1);
          end
        end
        STOP: begin
          if (tick == LAST_TICK) begin
            tick       <= '0;
            byte_valid <= rx_sync;
            rx_state   <= IDLE;
          end else begin
            tick <= tick + CW'(1);
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Image parser: header, big-endian word assembly, memory write strobes.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      p_state   <= P_HI;
      hdr_hi    <= 8'd0;
      remaining <= 12'd0;
      byte_cnt  <= 2'd0;
      word_acc  <= 24'd0;
      r_we      <= 1'b0;
      r_addr    <= 12'd0;
      r_wdata   <= 32'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Address advances after each write; wraps only after word 4095.
      if (r_we) r_addr <= r_addr + 12'd1;
      if (r_we && p_state == P_DONE) r_done <= 1'b1;
      case (p_state)
        P_HI: begin
          if (stop_bad) begin
            p_state <= P_ERR;
            r_err   <= 1'b1;
          end else if (byte_valid) begin
            hdr_hi <= rx_shift;
            if (rx_shift[7:4] != 4'd0) begin
              p_state <= P_ERR;
              r_err   <= 1'b1;
            end else begin
              p_state <= P_LO;
            end
          end
        end
        P_LO: begin
          if (stop_bad) begin
            p_state <= P_ERR;
            r_err   <= 1'b1;
          end else if (byte_valid) begin
            remaining <= {hdr_hi[3:0], rx_shift};
            byte_cnt  <= 2'd0;
            r_addr    <= 12'd0;
            p_state   <= P_DATA;
          end
        end
        P_DATA: begin
          if (stop_bad) begin
            // Partial word is dropped; no further writes.
            p_state <= P_ERR;
            r_err   <= 1'b1;
          end else if (byte_valid) begin
            word_acc <= {word_acc[15:0], rx_shift};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= {word_acc, rx_shift};
              if (remaining == 12'd0) begin
                p_state <= P_DONE;
              end else begin
                remaining <= remaining - 12'd1;
              end
            end
          end
        end
        P_DONE: p_state <= P_DONE;
        P_ERR: begin
          r_err   <= 1'b1;
          p_state <= P_ERR;
        end
        default: begin
          p_state <= P_ERR;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_uart_loader.sv
// Scoreboard bench for m_uart_loader: expected writes are queued as stimulus
// is issued; a monitor pops and compares on every r_we pulse.
module tb_m_uart_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    logic        last;
  } wr_t;
  wr_t exp_q[$];

  m_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .w_clk  (clk),
    .w_rst  (rst),
    .w_rxd  (rxd),
    .r_we   (we),
    .r_addr (addr),
    .r_wdata(wdata),
    .r_done (done),
    .r_err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d, input logic last);
    wr_t e;
    e.a = a; e.d = d; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cycles(CPB);
    end
    rxd = stop;
    cycles(CPB);
    rxd = 1'b1;
    cycles(3);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    {31'd0, we},    32'd0);
    check({tag, "_addr"},  {20'd0, addr},  32'd0);
    check({tag, "_wdata"}, wdata,          32'd0);
    check({tag, "_done"},  {31'd0, done},  32'd0);
    check({tag, "_err"},   {31'd0, err},   32'd0);
  endtask

  task automatic drain(input string tag);
    cycles(6);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%08h, none expected", addr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (addr !== e.a || wdata !== e.d) begin
          errors++;
          $display("FAIL write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                   addr, wdata, e.a, e.d);
        end
        if (e.last) begin
          @(negedge clk);
          checks++;
          if (done !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL done_after_last: got done=%b we=%b expected done=1 we=0", done, we);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // 1. Single word
    push(12'd0, 32'h20010020, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_word(32'h20010020);
    drain("s1");
    check("s1_done", {31'd0, done}, 32'd1);
    check("s1_err",  {31'd0, err},  32'd0);

    // 2. Three words, then extra bytes ignored
    do_reset();
    push(12'd0, 32'h00000020, 1'b0);
    push(12'd1, 32'h2001000A, 1'b0);
    push(12'd2, 32'h44000000, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_word(32'h00000020);
    send_word(32'h2001000A);
    send_word(32'h44000000);
    send_word(32'hDEADBEEF);
    send_byte(8'h55, 1'b0);
    drain("s2");
    check("s2_done", {31'd0, done}, 32'd1);
    check("s2_err",  {31'd0, err},  32'd0);

    // 3. Bad header
    do_reset();
    send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    send_word(32'h01020304);
    drain("s3");
    check("s3_err",  {31'd0, err},  32'd1);
    check("s3_done", {31'd0, done}, 32'd0);

    // 4. Framing error on 2nd byte of word 1
    do_reset();
    push(12'd0, 32'hAABBCCDD, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_word(32'hAABBCCDD);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    drain("s4");
    check("s4_err",  {31'd0, err},  32'd1);
    check("s4_done", {31'd0, done}, 32'd0);

    // 5. Glitch while idle, then a valid frame
    do_reset();
    rxd = 1'b0; cycles(2); rxd = 1'b1; cycles(3 * CPB);
    check("s5_glitch_err",  {31'd0, err},  32'd0);
    check("s5_glitch_done", {31'd0, done}, 32'd0);
    push(12'd0, 32'h12345678, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_word(32'h12345678);
    drain("s5");
    check("s5_done", {31'd0, done}, 32'd1);
    check("s5_err",  {31'd0, err},  32'd0);

    // 6. Reset after 2 of 4 words, then a fresh frame
    do_reset();
    push(12'd0, 32'h11111111, 1'b0);
    push(12'd1, 32'h22222222, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    send_word(32'h11111111);
    send_word(32'h22222222);
    check("s6_pre_reset_pending", exp_q.size(), 32'd0);
    check("s6_pre_reset_addr", {20'd0, addr}, 32'd2);
    rst = 1'b1; cycles(1); rst = 1'b0; cycles(1);
    check_idle_outputs("s6_after_reset");
    push(12'd0, 32'hCAFEF00D, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_word(32'hCAFEF00D);
    drain("s6");
    check("s6_done", {31'd0, done}, 32'd1);
    check("s6_err",  {31'd0, err},  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_uart_loader.md
# m_uart_loader

Serial program loader that writes a program image into the 4K-word instruction/data memory before the pipelined processor runs. It receives an 8N1 UART byte stream and parses a length header. It assembles big-endian 32-bit words and drives the memory write port (12-bit word address, write enable, 32-bit data) with one single-cycle write per word. It holds the processor in reset via `r_done` low until the whole image is written.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `w_clk`, in, 1: clock. All logic is on the rising edge.
- `w_rst`, in, 1: synchronous, active-high reset.
- `w_rxd`, in, 1: UART serial input, idle high, asynchronous to `w_clk`.
- `r_we`, out, 1: memory write enable, one-cycle pulse per word.
- `r_addr`, out, 12: word address of the current write.
- `r_wdata`, out, 32: word to write.
- `r_done`, out, 1: image fully written. The processor reset is `w_rst | ~r_done`.
- `r_err`, out, 1: sticky error flag.

## Operation
- **Input synchronizer.** `w_rxd` passes through a 2-flop synchronizer. All RX decisions use the synchronized value.
- **RX FSM states:** IDLE, START, BITS, STOP.
  - IDLE → START on a synchronized high→low edge.
  - START samples the line at `CLKS_PER_BIT/2` cycles (integer division). If the line is high there, the event is a glitch: return to IDLE, no byte, no error.
  - BITS samples 8 data bits, LSB first, each `CLKS_PER_BIT` cycles after the previous sample.
  - STOP samples once, `CLKS_PER_BIT` cycles after the last data bit.
  - Stop = 1 gives `byte_valid` for 1 cycle. Stop = 0 is a framing error.
  - After STOP the FSM returns to IDLE immediately, so back-to-back frames are accepted.
- **Frame format:** HDR_HI, HDR_LO, then 4·N data bytes.
  - Header = N−1, big-endian, 16 bits. Only bits [11:0] may be nonzero, so N = 1..4096.
  - Data words are big-endian: the first byte lands in [31:24].
- **Parser FSM states:** P_HI, P_LO, P_DATA, P_DONE, P_ERR.
  - P_HI: store the byte. If byte[7:4] ≠ 0 → P_ERR, else → P_LO.
  - P_LO: latch `remaining = {hi[3:0], byte}`, clear the byte counter, set `r_addr` = 0 → P_DATA.
  - P_DATA: shift the byte into the word assembly register and increment the 2-bit byte counter.
    - On the 4th byte, `r_we` = 1 and `r_wdata` = the assembled word on the next cycle.
    - If `remaining` = 0 → P_DONE, else decrement `remaining`.
  - After every `r_we` pulse, `r_addr` increments; it wraps 4095 → 0, which is only reachable at the final word.
  - P_DONE: `r_done` = 1. Further bytes, including framing errors, are ignored.
  - P_ERR: `r_err` = 1. No further `r_we` and `r_done` stays 0 until `w_rst`.
- **Framing error** in any parser state except P_DONE → P_ERR. The partial word is discarded.
- **Reset.** `w_rst` has priority over everything, including mid-byte and mid-word. Both FSMs go to IDLE/P_HI and all counters clear.

## Timing
- **Reset values:** `r_we`=0, `r_addr`=0, `r_wdata`=0, `r_done`=0, `r_err`=0.
- **Synchronizer latency** is 2 cycles from a `w_rxd` transition.
- **Byte latency:** `byte_valid` occurs on the cycle of the stop-bit sample + 1. That is about 9.5·`CLKS_PER_BIT` + 3 cycles after the start edge on `w_rxd`.
- **Write latency:** `r_we` is asserted exactly 1 cycle after the `byte_valid` of the 4th byte of a word.
  - `r_addr` and `r_wdata` are stable during that cycle.
  - `r_addr` increments on the following edge.
- **Done:** `r_done` rises on the same edge that deasserts the last `r_we`, i.e. 1 cycle after the final write. It stays high until `w_rst`.
- **Error:** `r_err` rises 1 cycle after the bad stop-bit sample.
- **No back-pressure.** The memory write port accepts a write every cycle. Successive writes are at least 4 byte-times apart.

## Test plan
Use `CLKS_PER_BIT`=8 for all scenarios.
1. **Single word.** Send 0x00,0x00, 0x20,0x01,0x00,0x20 → exactly one `r_we` with `r_addr`=0, `r_wdata`=0x20010020. `r_done`=1 on the next cycle, `r_err`=0.
2. **Three words.** Send 0x00,0x02 + 12 bytes (0x00000020, 0x2001000A, 0x44000000) → `r_we` at addresses 0,1,2 with matching data. `r_done` 1 cycle after the third write. Extra bytes sent afterwards → no `r_we`.
3. **Bad header.** Send 0x10,0x00 → `r_err`=1. Following data bytes → no `r_we`, `r_done`=0.
4. **Framing error.** Stop bit forced to 0 on the 2nd data byte of word 1 (N=2) → no `r_we` for word 1, `r_err`=1. Word 0 was already written at addr 0.
5. **Glitch.** `w_rxd` pulsed low for 2 cycles while idle → no `byte_valid`, parser unchanged. A subsequent valid frame loads correctly.
6. **Reset mid-load.** `w_rst` for 1 cycle after 2 of 4 words → all outputs return to 0. A fresh frame then writes starting at `r_addr`=0.
